// File: rtl/lcd_write_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_write_scheduler
//
// Turns keyboard characters into a paced stream of HD44780-style LCD words.
// Keys are buffered in a small FIFO. A scheduler FSM pops one key at a time,
// decodes it into 1..3 LCD words (data, cursor address, blanking), tracks the
// cursor position, and hands each word to the LCD driver. After power-up or
// reset, the FSM first sends the display initialisation sequence.
//
// Handshake with the LCD driver:
//   data_ready pulses for one cycle while lcd_word holds the word. The
//   scheduler then waits for busy_flag to go high (the driver accepted the
//   word) and then low (the transfer is finished). Only then does it present
//   the next word. lcd_word holds its value from the data_ready cycle until
//   busy_flag falls.
//
// Parameters
//   FIFO_DEPTH  key buffer entries (power of two, 2..16)
//   COLS        visible characters per LCD line (2..40)
//
// Ports
//   clk                 system clock, rising edge
//   internal_reset_lcd  asynchronous active-high reset
//   key_valid/key_char  one-cycle key strobe and its ASCII code
//   busy_flag           LCD driver busy
//   data_ready          one-cycle latch request for lcd_word
//   lcd_word            {RS, byte}; RS = 1 for data, 0 for instruction
//   cursor_row/col      current cursor position
//   fifo_full           key buffer full; strobes are dropped while high
//
// Optional feature
//   LCD_CLEAR_ON_WRAP_EN: a wrap from row 1 back to row 0 sends the clear
//   instruction (0x01) instead of a cursor address.
// ---------------------------------------------------------------------------
module lcd_write_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 16
) (
  input  logic       clk,
  input  logic       internal_reset_lcd,
  input  logic       key_valid,
  input  logic [7:0] key_char,
  input  logic       busy_flag,
  output logic       data_ready,
  output logic [8:0] lcd_word,
  output logic       cursor_row,
  output logic [5:0] cursor_col,
  output logic       fifo_full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [5:0]  COLS_C  = 6'(COLS);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    DECODE  = 3'd2,
    ISSUE   = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          push, pop;

  assign fifo_full = (fifo_cnt == DEPTH_C);
  assign push      = key_valid && !fifo_full;

  // The storage array carries no reset; occupancy is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= key_char;
  end

  always_ff @(posedge clk or posedge internal_reset_lcd) begin
    if (internal_reset_lcd) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A push and a pop in the same cycle leave the count unchanged.
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Word helpers
  // ---------------------------------------------------------------------
  function automatic logic [8:0] line_addr(input logic r, input logic [5:0] c);
    logic [7:0] base;
    base = r ? 8'hC0 : 8'h80;
    return {1'b0, base + {2'b00, c}};
  endfunction

  // Word sent when the cursor moves to column 0 of the other line. Enter and
  // automatic wrap share this word.
  function automatic logic [8:0] wrap_word(input logic r);
`ifdef LCD_CLEAR_ON_WRAP_EN
    return r ? 9'h001 : 9'h0C0;
`else
    return r ? 9'h080 : 9'h0C0;
`endif
  endfunction

  function automatic logic [8:0] init_word(input logic [1:0] step);
    case (step)
      2'd0:    return 9'h038;
      2'd1:    return 9'h00C;
      2'd2:    return 9'h006;
      default: return 9'h001;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Scheduler registers
  // ---------------------------------------------------------------------
  logic [7:0] dec_char;     // key popped in IDLE and decoded in DECODE
  logic [8:0] wq_a, wq_b;   // words still to issue after the current one
  logic [1:0] wq_left;      // number of valid entries in wq_a/wq_b
  logic [1:0] init_step;
  logic       init_active;

  // Combinational decode results and control strobes
  logic [8:0] dw0, dw1, dw2;
  logic [1:0] dcnt;
  logic       row_n;
  logic [5:0] col_n;
  logic       word_load;
  logic [8:0] word_val;
  logic       dec_commit, q_shift, init_adv, init_done;

  always_ff @(posedge clk or posedge internal_reset_lcd) begin
    if (internal_reset_lcd) state <= INIT;
    else                    state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    word_load  = 1'b0;
    word_val   = lcd_word;
    dec_commit = 1'b0;
    q_shift    = 1'b0;
    init_adv   = 1'b0;
    init_done  = 1'b0;
    dw0        = 9'h000;
    dw1        = 9'h000;
    dw2        = 9'h000;
    dcnt       = 2'd0;
    row_n      = cursor_row;
    col_n      = cursor_col;

    // Decode the popped key. The result is used only in DECODE.
    if (dec_char >= 8'h20 && dec_char <= 8'h7E) begin
      dw0  = {1'b1, dec_char};
      dcnt = 2'd1;
      if (cursor_col + 6'd1 == COLS_C) begin
        dw1   = wrap_word(cursor_row);
        dcnt  = 2'd2;
        row_n = ~cursor_row;
        col_n = 6'd0;
      end else begin
        col_n = cursor_col + 6'd1;
      end
    end else if (dec_char == 8'h0D) begin
      dw0   = wrap_word(cursor_row);
      dcnt  = 2'd1;
      row_n = ~cursor_row;
      col_n = 6'd0;
    end else if (dec_char == 8'h08 && cursor_col != 6'd0) begin
      // Step back, blank the cell, then leave the cursor on the blank cell.
      col_n = cursor_col - 6'd1;
      dw0   = line_addr(cursor_row, col_n);
      dw1   = 9'h120;
      dw2   = line_addr(cursor_row, col_n);
      dcnt  = 2'd3;
    end

    case (state)
      INIT: begin
        word_load  = 1'b1;
        word_val   = init_word(init_step);
        state_next = ISSUE;
      end
      IDLE: begin
        if (fifo_cnt != '0) begin
          pop        = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (dcnt == 2'd0) begin
          state_next = IDLE;
        end else begin
          dec_commit = 1'b1;
          word_load  = 1'b1;
          word_val   = dw0;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT_HI;
      WAIT_HI: if (busy_flag) state_next = WAIT_LO;
      WAIT_LO: begin
        if (!busy_flag) begin
          if (init_active) begin
            if (init_step == 2'd3) begin
              init_done  = 1'b1;
              state_next = IDLE;
            end else begin
              init_adv   = 1'b1;
              state_next = INIT;
            end
          end else if (wq_left != 2'd0) begin
            word_load  = 1'b1;
            word_val   = wq_a;
            q_shift    = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign data_ready = (state == ISSUE);

  always_ff @(posedge clk or posedge internal_reset_lcd) begin
    if (internal_reset_lcd) begin
      lcd_word    <= 9'h000;
      dec_char    <= 8'h00;
      wq_a        <= 9'h000;
      wq_b        <= 9'h000;
      wq_left     <= 2'd0;
      init_step   <= 2'd0;
      init_active <= 1'b1;
      cursor_row  <= 1'b0;
      cursor_col  <= 6'd0;
    end else begin
      if (word_load) lcd_word <= word_val;
      if (pop)       dec_char <= fifo_mem[rd_ptr];
      if (dec_commit) begin
        wq_a       <= dw1;
        wq_b       <= dw2;
        wq_left    <= dcnt - 2'd1;
        cursor_row <= row_n;
        cursor_col <= col_n;
      end
      if (q_shift) begin
        wq_a    <= wq_b;
        wq_left <= wq_left - 2'd1;
      end
      if (init_adv) init_step <= init_step + 2'd1;
      if (init_done) begin
        init_active <= 1'b0;
        cursor_row  <= 1'b0;
        cursor_col  <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_scheduler
//
// Directed bench for lcd_write_scheduler (FIFO_DEPTH = 4, COLS = 16).
// A responder models the LCD driver: it raises busy_flag for 3 cycles after
// each data_ready. busy_force holds busy high to stall the scheduler.
// A monitor logs every issued word into obs_q. Tests load expected words
// into exp_q, and drain_expect compares the two queues in order.
// ---------------------------------------------------------------------------
module tb_lcd_write_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_char;
  logic       busy_flag;
  logic       busy_resp;
  logic       busy_force;
  logic       data_ready;
  logic [8:0] lcd_word;
  logic       cursor_row;
  logic [5:0] cursor_col;
  logic       fifo_full;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic       prev_dr = 1'b0;

  assign busy_flag = busy_resp | busy_force;

  lcd_write_scheduler #(.FIFO_DEPTH(4), .COLS(16)) dut (
    .clk                (clk),
    .internal_reset_lcd (rst),
    .key_valid          (key_valid),
    .key_char           (key_char),
    .busy_flag          (busy_flag),
    .data_ready         (data_ready),
    .lcd_word           (lcd_word),
    .cursor_row         (cursor_row),
    .cursor_col         (cursor_col),
    .fifo_full          (fifo_full)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // LCD driver model: busy for 3 cycles after each accepted word.
  initial begin
    busy_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (data_ready && !rst) begin
        busy_resp = 1'b1;
        repeat (3) @(negedge clk);
        busy_resp = 1'b0;
      end
    end
  end

  // Word monitor. data_ready must never be high on two samples in a row.
  always @(negedge clk) begin
    if (!rst && data_ready) begin
      obs_q.push_back(lcd_word);
      check("dr_one_cycle", 32'(prev_dr), 32'd0);
    end
    prev_dr = data_ready;
  end

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_char  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic drain_expect(input string tag);
    int waited;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (obs_q.size() == 0) begin
        check({tag, "_timeout"}, 32'(obs_q.size()), 32'd1);
        exp_q.delete();
      end else begin
        check(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_cursor(input string tag, input logic r, input logic [5:0] c);
    check({tag, "_row"}, 32'(cursor_row), 32'(r));
    check({tag, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  task automatic expect_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    drain_expect("init_word");
    settle();
  endtask

  int lat;

  initial begin
    rst        = 1'b1;
    key_valid  = 1'b0;
    key_char   = 8'h00;
    busy_force = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_lcd_word", 32'(lcd_word), 32'h000);
    check_cursor("rst", 1'b0, 6'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    rst = 1'b0;

    // initialisation sequence
    expect_init();
    check_cursor("after_init", 1'b0, 6'd0);
    check("after_init_quiet", 32'(obs_q.size()), 32'd0);

    // 'A' with latency measurement: data_ready on the 4th cycle
    @(negedge clk);
    key_valid = 1'b1;
    key_char  = 8'h41;
    lat       = 0;
    @(negedge clk);
    key_valid = 1'b0;
    lat       = 1;
    while (!data_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    exp_q.push_back(9'h141);
    drain_expect("char_A");
    check_cursor("char_A", 1'b0, 6'd1);

    // backspace at col 1 returns to col 0
    send_key(8'h08);
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h120);
    exp_q.push_back(9'h080);
    drain_expect("bs_col1");
    check_cursor("bs_col1", 1'b0, 6'd0);

    // sixteen 'A' from (0,0) wrap to line 1
    for (int i = 0; i < 16; i++) begin
      send_key(8'h41);
      exp_q.push_back(9'h141);
      if (i == 15) exp_q.push_back(9'h0C0);
      drain_expect("row_fill");
    end
    settle();
    check_cursor("wrap", 1'b1, 6'd0);

    // backspace at col 0 and an unprintable code produce nothing
    send_key(8'h08);
    settle();
    check("bs_col0_quiet", 32'(obs_q.size()), 32'd0);
    check_cursor("bs_col0", 1'b1, 6'd0);
    send_key(8'h07);
    settle();
    check("ctrl_quiet", 32'(obs_q.size()), 32'd0);

    // Enter from line 1 back to line 0
    send_key(8'h0D);
`ifdef LCD_CLEAR_ON_WRAP_EN
    exp_q.push_back(9'h001);
`else
    exp_q.push_back(9'h080);
`endif
    drain_expect("enter_r1");
    check_cursor("enter_r1", 1'b0, 6'd0);

    // "abc" then backspace at col 3
    send_key(8'h61);
    send_key(8'h62);
    send_key(8'h63);
    exp_q.push_back(9'h161);
    exp_q.push_back(9'h162);
    exp_q.push_back(9'h163);
    drain_expect("abc");
    settle();
    check_cursor("abc", 1'b0, 6'd3);
    send_key(8'h08);
    exp_q.push_back(9'h082);
    exp_q.push_back(9'h120);
    exp_q.push_back(9'h082);
    drain_expect("bs_col3");
    check_cursor("bs_col3", 1'b0, 6'd2);
    settle();

    // FIFO fill while the driver stays busy
    busy_force = 1'b1;
    send_key(8'h31);
    repeat (6) @(negedge clk);
    send_key(8'h32);
    send_key(8'h33);
    send_key(8'h34);
    check("full_after_4", 32'(fifo_full), 32'd0);
    send_key(8'h35);
    check("full_after_5", 32'(fifo_full), 32'd1);
    send_key(8'h36);
    check("full_after_6", 32'(fifo_full), 32'd1);
    busy_force = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(9'h131 + 9'(i));
    drain_expect("fifo_drain");
    settle();
    check("sixth_dropped", 32'(obs_q.size()), 32'd0);
    check_cursor("fifo_drain", 1'b0, 6'd7);
    check("fifo_not_full", 32'(fifo_full), 32'd0);

    // reset while waiting for busy_flag to fall
    busy_force = 1'b1;
    send_key(8'h51);
    exp_q.push_back(9'h151);
    drain_expect("pre_reset");
    repeat (4) @(negedge clk);
    check("pre_reset_col", 32'(cursor_col), 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_data_ready", 32'(data_ready), 32'd0);
    check("mid_rst_lcd_word", 32'(lcd_word), 32'h000);
    check_cursor("mid_rst", 1'b0, 6'd0);
    check("mid_rst_fifo_full", 32'(fifo_full), 32'd0);
    // keys strobed during reset must be ignored
    @(negedge clk);
    key_valid  = 1'b1;
    key_char   = 8'h5A;
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    expect_init();
    check("no_key_in_reset", 32'(obs_q.size()), 32'd0);
    check_cursor("post_reset", 1'b0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
